// File: rtl/seg7_pkg.sv
// +----------------------------------------------------------------------+
// | seg7_pkg: segment bit positions and hex-to-segment lookup table.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package seg7_pkg;

  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Active-high patterns, entry 0 rightmost; point bit is always clear here.
  localparam logic [15:0][7:0] SEG_HEX_TABLE = {
    8'h8E, 8'h9E, 8'h7A, 8'h9C,   // F E d C
    8'h3E, 8'hEE, 8'hF6, 8'hFE,   // b A 9 8
    8'hE0, 8'hBE, 8'hB6, 8'h66,   // 7 6 5 4
    8'hF2, 8'hDA, 8'h60, 8'hFC    // 3 2 1 0
  };

endpackage

`default_nettype wire

// File: rtl/seg7_hex_decode.sv
// +----------------------------------------------------------------------+
// | seg7_hex_decode: nibble + point + blank -> active-high segments.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      o_seg         = SEG_HEX_TABLE[i_nibble];
      o_seg[SEG_DP] = i_dp;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_mux_driver.sv
// +----------------------------------------------------------------------+
// | seg7_mux_driver: time-multiplexed DIGITS-wide seven-segment driver   |
// | with tear-free shadow load and per-slot anti-ghost guard interval.   |
// | Optional SEG_DIM_EN adds BRIGHT port and 16-step PWM dimming.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_HZ         = 50_000_000,
  parameter int SLOT_HZ        = 1000,
  parameter int GUARD          = 16,
  parameter int EN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic [DIGITS-1:0]     DP,
  input  logic [DIGITS-1:0]     BLANK,
  input  logic                  LOAD,
`ifdef SEG_DIM_EN
  input  logic [3:0]            BRIGHT,
`endif
  output logic [DIGITS-1:0]     HEX_EN,
  output logic [7:0]            HEX_LED,
  output logic                  FRAME
);

  localparam int TICK_DIV = CLK_HZ / SLOT_HZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0]  C_SLOT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  C_SLOT_PRE   = CNT_W'(TICK_DIV - 2);
  localparam logic [CNT_W-1:0]  C_GUARD      = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]  C_DIGIT_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] C_EN_OFF     = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        C_SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  generate
    if (!(GUARD > 0 && GUARD < TICK_DIV)) begin : g_bad_guard
      $error("seg7_mux_driver: GUARD must satisfy 0 < GUARD < TICK_DIV");
    end
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("seg7_mux_driver: DIGITS must be 1..8");
    end
  endgenerate

  logic [CNT_W-1:0]    r_slot_cnt;
  logic [IDX_W-1:0]    r_digit;
  logic                r_pending;
  logic [4*DIGITS-1:0] r_sh_value, r_act_value;
  logic [DIGITS-1:0]   r_sh_dp, r_act_dp;
  logic [DIGITS-1:0]   r_sh_blank, r_act_blank;
  logic [DIGITS-1:0]   r_hex_en;
  logic [7:0]          r_hex_led;
  logic                r_frame;

  logic                w_slot_wrap;
  logic                w_boundary;
  logic                w_pre_boundary;
  logic                w_dim_on;
  logic [DIGITS-1:0]   w_en_raw;
  logic [3:0]          w_nibble;
  logic [7:0]          w_seg;

  assign w_slot_wrap    = (r_slot_cnt == C_SLOT_LAST);
  assign w_boundary     = w_slot_wrap && (r_digit == C_DIGIT_LAST);
  // FRAME is registered one cycle early so it coincides with the boundary state.
  assign w_pre_boundary = (r_slot_cnt == C_SLOT_PRE) && (r_digit == C_DIGIT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_slot_cnt <= '0;
      r_digit    <= '0;
    end else if (w_slot_wrap) begin
      r_slot_cnt <= '0;
      r_digit    <= (r_digit == C_DIGIT_LAST) ? '0 : r_digit + 1'b1;
    end else begin
      r_slot_cnt <= r_slot_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_pending   <= 1'b0;
      r_sh_value  <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '1;
      r_act_value <= '0;
      r_act_dp    <= '0;
      r_act_blank <= '1;
    end else begin
      if (LOAD) begin
        r_sh_value <= VALUE;
        r_sh_dp    <= DP;
        r_sh_blank <= BLANK;
      end
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (LOAD) begin
          r_act_value <= VALUE;
          r_act_dp    <= DP;
          r_act_blank <= BLANK;
        end else if (r_pending) begin
          r_act_value <= r_sh_value;
          r_act_dp    <= r_sh_dp;
          r_act_blank <= r_sh_blank;
        end
      end else if (LOAD) begin
        r_pending <= 1'b1;
      end
    end
  end

`ifdef SEG_DIM_EN
  logic [3:0] r_pwm;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) r_pwm <= 4'd0;
    else       r_pwm <= r_pwm + 4'd1;
  end

  assign w_dim_on = (r_pwm <= BRIGHT);
`else
  assign w_dim_on = 1'b1;
`endif

  assign w_en_raw = ((r_slot_cnt >= C_GUARD) && w_dim_on) ? (DIGITS'(1) << r_digit) : '0;
  assign w_nibble = r_act_value[{r_digit, 2'b00} +: 4];

  seg7_hex_decode u_decode (
    .i_nibble (w_nibble),
    .i_dp     (r_act_dp[r_digit]),
    .i_blank  (r_act_blank[r_digit]),
    .o_seg    (w_seg)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_hex_en  <= C_EN_OFF;
      r_hex_led <= C_SEG_OFF;
      r_frame   <= 1'b0;
    end else begin
      r_hex_en  <= w_en_raw ^ C_EN_OFF;
      r_hex_led <= w_seg ^ C_SEG_OFF;
      r_frame   <= w_pre_boundary;
    end
  end

  assign HEX_EN  = r_hex_en;
  assign HEX_LED = r_hex_led;
  assign FRAME   = r_frame;

endmodule

`default_nettype wire
